// File: rtl/time_entry_pkg.sv
// time_entry_pkg: shared types, cursor codes and digit-increment helper for the MM:SS preset entry block.
package time_entry_pkg;
  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;
  localparam logic [1:0] CUR_MT = 2'd0;
  localparam logic [1:0] CUR_MU = 2'd1;
  localparam logic [1:0] CUR_ST = 2'd2;
  localparam logic [1:0] CUR_SU = 2'd3;
  localparam logic [2:0] TENS_MAX = 3'd5;
  localparam logic [3:0] UNITS_MAX = 4'd9;
  typedef struct packed {
    logic [2:0] mt;
    logic [3:0] mu;
    logic [2:0] st;
    logic [3:0] su;
  } digits_t;
  // Increment only the selected digit, wrapping independently (no carry).
  function automatic digits_t bump(digits_t d, logic [1:0] c);
    digits_t r;
    r = d;
    case (c)
      CUR_MT:  r.mt = (d.mt == TENS_MAX) ? 3'd0 : d.mt + 3'd1;
      CUR_MU:  r.mu = (d.mu == UNITS_MAX) ? 4'd0 : d.mu + 4'd1;
      CUR_ST:  r.st = (d.st == TENS_MAX) ? 3'd0 : d.st + 3'd1;
      default: r.su = (d.su == UNITS_MAX) ? 4'd0 : d.su + 4'd1;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/hold_repeat.sv
// hold_repeat: rise detector plus hold/auto-repeat step generator for one button level.
//   clock, clear_n : clock, async active-low reset
//   level          : debounced button level
//   flush          : clears the hold counter (restarts the hold phase)
//   step           : one-cycle pulse on the rise edge, after HOLD_CYCLES, then every REPEAT_CYCLES
module hold_repeat #(
  parameter int HOLD_CYCLES = 3,
  parameter int REPEAT_CYCLES = 7
) (
  input  logic clock,
  input  logic clear_n,
  input  logic level,
  input  logic flush,
  output logic step
);
  localparam int MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] HC = W'(HOLD_CYCLES);
  localparam logic [W-1:0] RC = W'(REPEAT_CYCLES);
  logic prev, first, hit;
  logic [W-1:0] cnt;
  // cnt counts edges since the last step; first selects the hold vs repeat interval.
  assign hit = level & prev & (cnt == (first ? HC : RC));
  assign step = level & (~prev | hit);
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      prev <= 1'b0;
      first <= 1'b1;
      cnt <= '0;
    end else begin
      prev <= level;
      if (flush || !level) begin
        cnt <= '0;
        first <= 1'b1;
      end else if (!prev) begin
        cnt <= W'(1);
        first <= 1'b1;
      end else if (hit) begin
        cnt <= W'(1);
        first <= 1'b0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end
endmodule

// File: rtl/time_entry_ctrl.sv
// time_entry_ctrl: MM:SS preset entry FSM (enter/inc/next/cancel) with shadow restore and commit pulse.
//   clock, clear_n        : clock, async active-low reset
//   enter, inc, next, cancel : debounced button levels
//   min_tens..sec_units   : current BCD digits
//   cursor                : digit under edit (0=min_tens .. 3=sec_units)
//   editing, value_valid, done : session active, committed value nonzero, commit pulse
module time_entry_ctrl
  import time_entry_pkg::*;
#(
  parameter int HOLD_CYCLES = 3,
  parameter int REPEAT_CYCLES = 7
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       enter,
  input  logic       inc,
  input  logic       next,
  input  logic       cancel,
  output logic [2:0] min_tens,
  output logic [3:0] min_units,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_units,
  output logic [1:0] cursor,
  output logic       editing,
  output logic       value_valid,
  output logic       done
);
  state_t state, state_n;
  digits_t dig, dig_n, shadow, shadow_n;
  logic [1:0] cursor_n;
  logic enter_q, next_q, enter_rise, next_rise, step, flush;
  assign enter_rise = enter & ~enter_q;
  assign next_rise = next & ~next_q;
  assign {min_tens, min_units, sec_tens, sec_units} = dig;
  hold_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_hold (
    .clock(clock),
    .clear_n(clear_n),
    .level(inc),
    .flush(flush),
    .step(step)
  );
  always_comb begin
    state_n = state;
    cursor_n = cursor;
    dig_n = dig;
    shadow_n = shadow;
    flush = 1'b0;
    case (state)
      IDLE: if (enter_rise) begin
        state_n = EDIT;
        cursor_n = CUR_MT;
        shadow_n = dig;
      end
      EDIT: if (cancel) begin
        flush = 1'b1;
        dig_n = shadow;
        cursor_n = CUR_MT;
        state_n = IDLE;
      end else if (next_rise) begin
        // A next rise swallows any coincident inc step and restarts the hold timing.
        flush = 1'b1;
        state_n = (cursor == CUR_SU) ? COMMIT : EDIT;
        cursor_n = (cursor == CUR_SU) ? cursor : cursor + 2'd1;
      end else if (step) begin
        dig_n = bump(dig, cursor);
      end
      default: begin
        state_n = IDLE;
        cursor_n = CUR_MT;
      end
    endcase
  end
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      dig <= '0;
      shadow <= '0;
      cursor <= CUR_MT;
      editing <= 1'b0;
      done <= 1'b0;
      value_valid <= 1'b0;
      enter_q <= 1'b0;
      next_q <= 1'b0;
    end else begin
      state <= state_n;
      dig <= dig_n;
      shadow <= shadow_n;
      cursor <= cursor_n;
      editing <= (state_n == EDIT);
      done <= (state_n == COMMIT);
      // Latched on entry to COMMIT so it is already valid while done is high.
      if (state_n == COMMIT) value_valid <= |dig_n;
      enter_q <= enter;
      next_q <= next;
    end
  end
endmodule

// File: tb/tb_time_entry_ctrl.sv
// tb_time_entry_ctrl: scoreboard bench with directed and random button stimulus against a behavioural model.
module tb_time_entry_ctrl;
  localparam int H = 3;
  localparam int R = 7;
  logic clock = 1'b0, clear_n = 1'b0;
  logic enter = 1'b0, inc = 1'b0, next = 1'b0, cancel = 1'b0;
  logic [2:0] min_tens, sec_tens;
  logic [3:0] min_units, sec_units;
  logic [1:0] cursor;
  logic editing, value_valid, done;
  logic [18:0] act;
  logic [18:0] sb[$];
  logic [18:0] exp_v;
  int errors = 0, checks = 0;
  int dg[4], sh[4];
  int cur, mode, t, inc_left;
  bit vv, pe, pi, pn, re, ri, rn, rc;

  always #5 clock = ~clock;

  time_entry_ctrl #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .clock(clock), .clear_n(clear_n), .enter(enter), .inc(inc), .next(next), .cancel(cancel),
    .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens), .sec_units(sec_units),
    .cursor(cursor), .editing(editing), .value_valid(value_valid), .done(done)
  );

  assign act = {min_tens, min_units, sec_tens, sec_units, cursor, editing, done, value_valid};

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL outputs {mt,mu,st,su,cur,edit,done,vv} got %0d%0d:%0d%0d c%0d e%b d%b v%b want %0d%0d:%0d%0d c%0d e%b d%b v%b",
          act[18:16], act[15:12], act[11:9], act[8:5], act[4:3], act[2], act[1], act[0],
          exp_v[18:16], exp_v[15:12], exp_v[11:9], exp_v[8:5], exp_v[4:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  function automatic logic [18:0] model_out();
    return {3'(dg[0]), 4'(dg[1]), 3'(dg[2]), 4'(dg[3]), 2'(cur), mode == 1, mode == 2, vv};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin dg[k] = 0; sh[k] = 0; end
    cur = 0; mode = 0; vv = 0; pe = 0; pi = 0; pn = 0; t = -1;
  endtask

  // One clock edge of the preset-entry rules, written from the behavioural description.
  task automatic model_step(input bit e, input bit i, input bit n, input bit c);
    bit er, nr, stp;
    er = e && !pe;
    nr = n && !pn;
    if (!i) t = -1;
    else if (!pi) t = 0;
    else t++;
    stp = i && (t == 0 || t == H || (t > H && (t - H) % R == 0));
    if (mode == 0) begin
      if (er) begin mode = 1; cur = 0; sh = dg; end
    end else if (mode == 1) begin
      if (c) begin dg = sh; cur = 0; mode = 0; end
      else if (nr) begin
        if (cur == 3) begin
          mode = 2;
          vv = (dg[0] + dg[1] + dg[2] + dg[3]) != 0;
        end else cur++;
      end else if (stp) dg[cur] = (dg[cur] + 1) % ((cur % 2 == 0) ? 6 : 10);
    end else begin
      mode = 0; cur = 0;
    end
    pe = e; pi = i; pn = n;
  endtask

  task automatic cyc(input bit e, input bit i, input bit n, input bit c);
    @(negedge clock);
    enter = e; inc = i; next = n; cancel = c;
    @(posedge clock);
    model_step(e, i, n, c);
    sb.push_back(model_out());
  endtask

  task automatic press_inc(input int k);
    repeat (k) begin cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); end
  endtask

  task automatic press_next();
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
  endtask

  task automatic press_enter();
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    clear_n = 1'b0;
    enter = 0; inc = 0; next = 0; cancel = 0;
    #1;
    checks++;
    if (act !== 19'd0) begin
      errors++;
      $display("FAIL async_reset got %h want 0", act);
    end
    model_reset();
    @(negedge clock);
    @(negedge clock);
    clear_n = 1'b1;
  endtask

  initial begin
    model_reset();
    inc_left = 0;
    do_reset();
    press_enter();
    press_inc(7);
    repeat (3) press_next();
    press_inc(12);
    repeat (18) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    press_enter();
    press_inc(1); press_next();
    press_inc(2); press_next();
    press_inc(3); press_next();
    press_inc(4); press_next();
    cyc(0, 0, 0, 0);
    press_enter();
    press_inc(4);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    press_enter();
    cyc(0, 1, 1, 1);
    cyc(0, 0, 0, 0);
    press_enter();
    press_next();
    press_next();
    press_inc(2);
    do_reset();
    press_enter();
    repeat (4) press_next();
    cyc(0, 0, 0, 0);
    repeat (3000) begin
      if (inc_left > 0) begin
        ri = 1; inc_left--;
      end else begin
        ri = 0;
        if ($urandom_range(0, 3) == 0) inc_left = $urandom_range(1, 20);
      end
      re = $urandom_range(0, 5) == 0;
      rn = !ri && $urandom_range(0, 2) == 0;
      rc = !ri && $urandom_range(0, 40) == 0;
      cyc(re, ri, rn, rc);
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    @(negedge clock);
    @(negedge clock);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
